// File: rtl/bram_stream_reader_if.sv
// Stream/ROM bundle for bram_stream_reader.
// Ports: ROM side (ram_enable, address, ram_data), stream side (out_*).
interface bram_stream_reader_if #(
    parameter int RAM_WIDTH = 8,
    parameter int ADDR_SIZE = 8
);
    logic                 ram_enable;
    logic [ADDR_SIZE-1:0] address;
    logic [RAM_WIDTH-1:0] ram_data;
    logic [RAM_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output ram_enable,
        output address,
        input  ram_data,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  ram_enable,
        input  address,
        output ram_data,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Walks ROM addresses START_ADDR..END_ADDR and streams the words out.
// Ports: clock, reset (async high), start, busy, done, bus (ROM + stream).
module bram_stream_reader #(
    parameter int RAM_WIDTH  = 8,
    parameter int ADDR_SIZE  = 8,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 2**ADDR_SIZE-1
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    bram_stream_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [ADDR_SIZE-1:0] FIRST = ADDR_SIZE'(START_ADDR);
    localparam logic [ADDR_SIZE-1:0] LAST  = ADDR_SIZE'(END_ADDR);

    state_t               state, state_nxt;
    logic [ADDR_SIZE-1:0] addr;
    logic                 pend;
    logic                 pend_last;
    logic [RAM_WIDTH-1:0] mem_data [2];
    logic                 mem_last [2];
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           count;
    logic                 pop, issue, at_end;
    logic [2:0]           occ;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done      = 1'b0;
        at_end    = (addr == LAST);
        pop       = (count != 2'd0) & bus.out_ready;
        occ       = {1'b0, count} + {2'b0, pend};
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                // Words buffered plus in flight after this edge stay <= 2.
                issue = (occ <= 3'd1 + {2'b0, pop});
                if (issue && at_end)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && bus.out_last) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy           = (state != IDLE);
    assign bus.ram_enable = issue;
    assign bus.address    = addr;
    assign bus.out_valid  = (count != 2'd0);
    assign bus.out_data   = mem_data[rd_ptr];
    assign bus.out_last   = (count != 2'd0) & mem_last[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr      <= FIRST;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
        end else begin
            if (state == IDLE && start)
                addr <= FIRST;
            else if (issue && !at_end)
                addr <= addr + ADDR_SIZE'(1);
            // Remember whether the read now in the ROM was the final one.
            pend      <= issue;
            pend_last <= issue & at_end;
            if (pend) begin
                mem_data[wr_ptr] <= bus.ram_data;
                mem_last[wr_ptr] <= pend_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (pend && !pop)
                count <= count + 2'd1;
            else if (!pend && pop)
                count <= count - 2'd1;
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Testbench for bram_stream_reader: three configurations, ROM models,
// scoreboard of expected {last,data} pushed at start, popped on handshake.
module tb_bram_stream_reader;
    logic       clk = 1'b0;
    bit         run = 1'b1;
    logic       rst;
    logic [2:0] st;
    logic [2:0] rdy;
    wire  [2:0] bz;
    wire  [2:0] dn;

    always #5 if (run) clk = ~clk;

    bram_stream_reader_if #(.RAM_WIDTH(8), .ADDR_SIZE(8)) if0 ();
    bram_stream_reader_if #(.RAM_WIDTH(8), .ADDR_SIZE(8)) if1 ();
    bram_stream_reader_if #(.RAM_WIDTH(8), .ADDR_SIZE(8)) if2 ();

    bram_stream_reader #(
        .RAM_WIDTH(8), .ADDR_SIZE(8), .START_ADDR(2), .END_ADDR(5)
    ) dut0 (
        .clock(clk), .reset(rst), .start(st[0]),
        .busy(bz[0]), .done(dn[0]), .bus(if0.master)
    );

    bram_stream_reader #(
        .RAM_WIDTH(8), .ADDR_SIZE(8), .START_ADDR(9), .END_ADDR(9)
    ) dut1 (
        .clock(clk), .reset(rst), .start(st[1]),
        .busy(bz[1]), .done(dn[1]), .bus(if1.master)
    );

    bram_stream_reader #(
        .RAM_WIDTH(8), .ADDR_SIZE(8), .START_ADDR(252), .END_ADDR(255)
    ) dut2 (
        .clock(clk), .reset(rst), .start(st[2]),
        .busy(bz[2]), .done(dn[2]), .bus(if2.master)
    );

    assign if0.out_ready = rdy[0];
    assign if1.out_ready = rdy[1];
    assign if2.out_ready = rdy[2];

    // Synchronous ROMs: ROM[a] = a ^ 8'hA5, one cycle latency.
    always @(posedge clk) if (if0.ram_enable) if0.ram_data <= if0.address ^ 8'hA5;
    always @(posedge clk) if (if1.ram_enable) if1.ram_data <= if1.address ^ 8'hA5;
    always @(posedge clk) if (if2.ram_enable) if2.ram_data <= if2.address ^ 8'hA5;

    logic [8:0] sb[$];
    int         checks = 0;
    int         failures = 0;
    int         issued, popped, en_cnt;
    bit         stall_prev, done_seen;
    logic [7:0] held;
    logic       o_en, o_ov, o_ol, o_bz, o_dn;
    logic [7:0] o_ad, o_od;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int i);
        case (i)
            0: begin
                o_en = if0.ram_enable; o_ad = if0.address; o_ov = if0.out_valid;
                o_od = if0.out_data; o_ol = if0.out_last; o_bz = bz[0]; o_dn = dn[0];
            end
            1: begin
                o_en = if1.ram_enable; o_ad = if1.address; o_ov = if1.out_valid;
                o_od = if1.out_data; o_ol = if1.out_last; o_bz = bz[1]; o_dn = dn[1];
            end
            default: begin
                o_en = if2.ram_enable; o_ad = if2.address; o_ov = if2.out_valid;
                o_od = if2.out_data; o_ol = if2.out_last; o_bz = bz[2]; o_dn = dn[2];
            end
        endcase
    endtask

    task automatic clear();
        sb.delete();
        issued = 0;
        popped = 0;
        en_cnt = 0;
        stall_prev = 1'b0;
        done_seen = 1'b0;
    endtask

    task automatic push_pass(input int lo, input int hi);
        for (int a = lo; a <= hi; a++)
            sb.push_back({a == hi, 8'(a) ^ 8'hA5});
    endtask

    // One clock cycle: drive inputs after the falling edge, sample 1ns later.
    task automatic cyc(input int i, input logic s, input logic r);
        logic [8:0] e;
        logic       p;
        @(negedge clk);
        st     = 3'b000;
        st[i]  = s;
        rdy[i] = r;
        #1;
        sample(i);
        p = o_ov & r;
        if (stall_prev) begin
            chk("stall_valid", o_ov, 1);
            chk("stall_data", o_od, held);
        end
        if (p) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("data", o_od, e[7:0]);
                chk("last", o_ol, e[8]);
                chk("done", o_dn, e[8]);
            end
        end else begin
            chk("done_nopop", o_dn, 0);
        end
        if (o_dn === 1'b1) done_seen = 1'b1;
        if (o_en === 1'b1) begin
            issued++;
            en_cnt++;
        end
        if (p === 1'b1) popped++;
        chk("outstanding", (issued - popped) <= 2, 1);
        stall_prev = (o_ov === 1'b1) && !r;
        held = o_od;
    endtask

    task automatic pass2(input string pfx);
        clear();
        push_pass(2, 5);
        for (int c = 0; c < 10; c++) begin
            cyc(0, c == 0, 1'b1);
            chk({pfx, "_en"}, o_en, c >= 1 && c <= 4);
            chk({pfx, "_valid"}, o_ov, c >= 3 && c <= 6);
            chk({pfx, "_busy"}, o_bz, c >= 1 && c <= 6);
            if (c >= 1 && c <= 4)
                chk({pfx, "_addr"}, o_ad, c + 1);
        end
        chk({pfx, "_drained"}, sb.size(), 0);
        chk({pfx, "_done_seen"}, done_seen, 1);
    endtask

    initial begin
        logic [7:0] first_addr [3];
        first_addr[0] = 8'd2;
        first_addr[1] = 8'd9;
        first_addr[2] = 8'd252;
        st  = 3'b000;
        rdy = 3'b000;
        rst = 1'b1;
        #12 rst = 1'b0;

        // Test 1: asynchronous reset with the clock stopped.
        clear();
        cyc(0, 1'b1, 1'b0);
        cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        chk("pre_reset_valid", o_ov, 1);
        @(negedge clk);
        run = 1'b0;
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            sample(i);
            chk("rst_busy", o_bz, 0);
            chk("rst_done", o_dn, 0);
            chk("rst_en", o_en, 0);
            chk("rst_addr", o_ad, first_addr[i]);
            chk("rst_valid", o_ov, 0);
            chk("rst_last", o_ol, 0);
            chk("rst_data", o_od, 0);
        end
        #5 rst = 1'b0;
        #2 run = 1'b1;
        rdy = 3'b111;

        // Test 2: full-speed pass 2..5.
        pass2("t2");

        // Test 3: backpressure in cycles 4-8.
        clear();
        push_pass(2, 5);
        for (int c = 0; c < 16; c++) begin
            cyc(0, c == 0, !(c >= 4 && c <= 8));
            if (c >= 4 && c <= 8) chk("t3_en_stall", o_en, 0);
            if (c == 9) chk("t3_resume", o_en, 1);
        end
        chk("t3_drained", sb.size(), 0);
        chk("t3_done_seen", done_seen, 1);
        chk("t3_reads", en_cnt, 4);

        // Test 6: reset in the middle of a pass, then a fresh pass.
        clear();
        push_pass(2, 5);
        for (int c = 0; c < 5; c++)
            cyc(0, c == 0, 1'b1);
        #2 rst = 1'b1;
        #1;
        sample(0);
        chk("t6_valid", o_ov, 0);
        chk("t6_busy", o_bz, 0);
        chk("t6_done", o_dn, 0);
        chk("t6_en", o_en, 0);
        chk("t6_addr", o_ad, 2);
        @(negedge clk);
        rst = 1'b0;
        pass2("t6");

        // Test 4: single-word window at address 9.
        clear();
        sb.push_back({1'b1, 8'hAC});
        for (int c = 0; c < 8; c++) begin
            cyc(1, c == 0, 1'b1);
            chk("t4_en", o_en, c == 1);
            chk("t4_valid", o_ov, c == 3);
        end
        chk("t4_reads", en_cnt, 1);
        chk("t4_done_seen", done_seen, 1);
        chk("t4_drained", sb.size(), 0);

        // Test 5: window at the top of the address space, restart after done.
        clear();
        push_pass(252, 255);
        for (int c = 0; c < 7; c++) begin
            cyc(2, c == 0 || c == 2 || c == 6, 1'b1);
            chk("t5_no_wrap", o_ad >= 8'd252, 1);
            if (c >= 1 && c <= 4) chk("t5_addr", o_ad, 251 + c);
            if (c >= 5) chk("t5_addr_hold", o_ad, 255);
            if (c == 6) chk("t5_done", o_dn, 1);
        end
        push_pass(252, 255);
        for (int c = 7; c < 17; c++) begin
            cyc(2, c == 7, 1'b1);
            chk("t5b_no_wrap", o_ad >= 8'd252, 1);
            if (c == 7) chk("t5b_idle", o_bz, 0);
            if (c == 8) begin
                chk("t5b_busy", o_bz, 1);
                chk("t5b_en", o_en, 1);
                chk("t5b_addr", o_ad, 252);
            end
        end
        chk("t5_reads", en_cnt, 8);
        chk("t5_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
